instr_encode_loader: RTL and testbench

- Inverse of the core's instruction decode stage. Takes field-level instruction descriptions (type enables, opcode, func3, func7, register indices, immediate) and packs them into 32-bit RV32I instruction words.
- Writes the packed words sequentially into instruction memory through a simple write port.
- Used by the program-load path and by testbenches to build instruction memory images.
- Immediate field conventions exactly invert the decode stage's extraction.

---
 rtl/instr_encode_loader_if.sv | 51 +++++
 rtl/instr_encode_loader.sv | 145 ++++++++++++++
 tb/tb_instr_encode_loader.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encode_loader_if.sv
// Bundles the load-session control, field-level instruction inputs and the memory write port of
// instr_encode_loader. The bench drives the master side and the loader uses the slave side.
//   control : start_i, base_addr_i, count_i -> busy_o, done_o, err_o, wr_count_o
//   fields  : in_valid_i/in_ready_o handshake, type enables, opcode, func3/7, regs, immediate
//   memory  : mem_we_o, mem_addr_o, mem_wdata_o
interface instr_encode_loader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 8
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [CNT_W-1:0]  count_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              R_EN_i;
  logic              I_EN_i;
  logic              S_EN_i;
  logic              SB_EN_i;
  logic              U_EN_i;
  logic              UJ_EN_i;
  logic [6:0]        opcode_i;
  logic [2:0]        func3_i;
  logic [6:0]        func7_i;
  logic [4:0]        RD_i;
  logic [4:0]        RS1_i;
  logic [4:0]        RS2_i;
  logic [31:0]       immed_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [CNT_W-1:0]  wr_count_o;

  modport master (
    output start_i, base_addr_i, count_i, in_valid_i,
    output R_EN_i, I_EN_i, S_EN_i, SB_EN_i, U_EN_i, UJ_EN_i,
    output opcode_i, func3_i, func7_i, RD_i, RS1_i, RS2_i, immed_i,
    input  in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  busy_o, done_o, err_o, wr_count_o
  );

  modport slave (
    input  start_i, base_addr_i, count_i, in_valid_i,
    input  R_EN_i, I_EN_i, S_EN_i, SB_EN_i, U_EN_i, UJ_EN_i,
    input  opcode_i, func3_i, func7_i, RD_i, RS1_i, RS2_i, immed_i,
    output in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output busy_o, done_o, err_o, wr_count_o
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Packs field-level instruction descriptions into RV32I words (inverse of the decode stage's
// field extraction) and writes them to consecutive word addresses of instruction memory.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset
//   bus   - slave side of instr_encode_loader_if (session control, field handshake, write port)
// A session consumes count_i field transfers; each legal one yields a single-cycle write one
// cycle after it is accepted. Transfers with zero or several type enables are consumed but only
// raise the sticky error flag.
module instr_encode_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  instr_encode_loader_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(4);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;

  logic [5:0]  type_en;
  logic        legal;
  logic        in_ready;
  logic        xfer;
  logic [31:0] enc;
  logic        unused_imm_hi;

  // Only the low 20 immediate bits ever reach the encoded word.
  assign unused_imm_hi = ^bus.immed_i[31:20];

  assign type_en  = {bus.R_EN_i, bus.I_EN_i, bus.S_EN_i, bus.SB_EN_i, bus.U_EN_i, bus.UJ_EN_i};
  assign legal    = $onehot(type_en);
  assign in_ready = (state_q == LOAD) && (remain_q != '0);
  assign xfer     = bus.in_valid_i && in_ready;

  // SB/UJ immediates arrive already halved (byte offset >> 1), so imm[0] is offset bit 1.
  always_comb begin
    enc = '0;
    unique case (type_en)
      6'b100000: enc = {bus.func7_i, bus.RS2_i, bus.RS1_i, bus.func3_i, bus.RD_i, bus.opcode_i};
      6'b010000: enc = {bus.immed_i[11:0], bus.RS1_i, bus.func3_i, bus.RD_i, bus.opcode_i};
      6'b001000: enc = {bus.immed_i[11:5], bus.RS2_i, bus.RS1_i, bus.func3_i,
                        bus.immed_i[4:0], bus.opcode_i};
      6'b000100: enc = {bus.immed_i[11], bus.immed_i[9:4], bus.RS2_i, bus.RS1_i, bus.func3_i,
                        bus.immed_i[3:0], bus.immed_i[10], bus.opcode_i};
      6'b000010: enc = {bus.immed_i[19:0], bus.RD_i, bus.opcode_i};
      6'b000001: enc = {bus.immed_i[19], bus.immed_i[9:0], bus.immed_i[10],
                        bus.immed_i[18:11], bus.RD_i, bus.opcode_i};
      default:   enc = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    err_d       = err_q;
    wr_count_d  = wr_count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          addr_d     = {bus.base_addr_i[ADDR_W-1:2], 2'b00};
          remain_d   = bus.count_i;
          err_d      = 1'b0;
          wr_count_d = '0;
          state_d    = (bus.count_i == '0) ? FLUSH : LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          remain_d = remain_q - CntOne;
          if (legal) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = enc;
            addr_d      = addr_q + AddrStep;
            wr_count_d  = wr_count_q + CntOne;
          end else begin
            err_d = 1'b1;
          end
          if (remain_q == CntOne) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The last write is on the bus this cycle; done follows once it has landed.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      err_q       <= 1'b0;
      wr_count_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      err_q       <= err_d;
      wr_count_q  <= wr_count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.busy_o      = (state_q == LOAD) || (state_q == FLUSH);
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: table vectors for the known encodings plus hand sequences for
// illegal types, wrap, count zero, ignored start and mid-session reset, then random sessions
// checked against an offset-based RV32I encoding model.
module tb_instr_encode_loader;

  localparam logic [5:0] TR  = 6'b100000;
  localparam logic [5:0] TI  = 6'b010000;
  localparam logic [5:0] TS  = 6'b001000;
  localparam logic [5:0] TSB = 6'b000100;
  localparam logic [5:0] TU  = 6'b000010;
  localparam logic [5:0] TUJ = 6'b000001;

  typedef struct {
    logic [5:0]  en;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fld_t;

  typedef struct {
    fld_t        f;
    logic [31:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encode_loader_if #(.ADDR_W(10), .CNT_W(8)) bus ();

  instr_encode_loader #(.ADDR_W(10), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Monitor: log every write and the cycle of writes/done, count busy cycles.
  int          cyc = 0;
  logic [9:0]  log_a[$];
  logic [31:0] log_w[$];
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  int          busy_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we_o) begin
      log_a.push_back(bus.mem_addr_o);
      log_w.push_back(bus.mem_wdata_o);
      last_we_cyc = cyc;
    end
    if (bus.done_o) done_cyc = cyc;
    if (bus.busy_o) busy_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic fld_t mk(input logic [5:0] en, input logic [6:0] opc, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
    fld_t f;
    f.en = en; f.opc = opc; f.f3 = f3; f.f7 = f7;
    f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.imm = imm;
    return f;
  endfunction

  function automatic int unsigned bits(input int unsigned x, input int hi, input int lo);
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
  endfunction

  // Reference encoder built from the RV32I field positions of the real byte offset.
  function automatic logic [31:0] ref_encode(input fld_t f);
    int unsigned im  = f.imm;
    int unsigned off = f.imm * 2;
    int unsigned rd  = f.rd;
    int unsigned rs1 = f.rs1;
    int unsigned rs2 = f.rs2;
    int unsigned f3  = f.f3;
    int unsigned f7  = f.f7;
    int unsigned w   = f.opc;
    case (f.en)
      TR:  w += rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * (1 << 20) + f7 * (1 << 25);
      TI:  w += rd * 128 + f3 * 4096 + rs1 * 32768 + bits(im, 11, 0) * (1 << 20);
      TS:  w += bits(im, 4, 0) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * (1 << 20)
                + bits(im, 11, 5) * (1 << 25);
      TSB: w += bits(off, 11, 11) * 128 + bits(off, 4, 1) * 256 + f3 * 4096 + rs1 * 32768
                + rs2 * (1 << 20) + bits(off, 10, 5) * (1 << 25) + bits(off, 12, 12) * (1 << 31);
      TU:  w += rd * 128 + bits(im, 19, 0) * 4096;
      TUJ: w += rd * 128 + bits(off, 19, 12) * 4096 + bits(off, 11, 11) * (1 << 20)
                + bits(off, 10, 1) * (1 << 21) + bits(off, 20, 20) * (1 << 31);
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic drive(input fld_t f);
    {bus.R_EN_i, bus.I_EN_i, bus.S_EN_i, bus.SB_EN_i, bus.U_EN_i, bus.UJ_EN_i} = f.en;
    bus.opcode_i = f.opc; bus.func3_i = f.f3; bus.func7_i = f.f7;
    bus.RD_i = f.rd; bus.RS1_i = f.rs1; bus.RS2_i = f.rs2; bus.immed_i = f.imm;
  endtask

  int st_cyc;
  task automatic do_start(input logic [9:0] base, input logic [7:0] cnt);
    @(negedge clk);
    bus.start_i = 1'b1; bus.base_addr_i = base; bus.count_i = cnt;
    @(negedge clk);
    bus.start_i = 1'b0;
    st_cyc = cyc;
  endtask

  task automatic xfer(input fld_t f);
    @(negedge clk);
    drive(f);
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 40 && !bus.in_ready_o; k++) @(negedge clk);
    check("in_ready before transfer", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.done_o) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({name, " done seen"}, 32'(got), 32'd1);
    #1;
  endtask

  task automatic clear_logs();
    log_a.delete(); log_w.delete();
    last_we_cyc = -1; done_cyc = -1; busy_n = 0;
  endtask

  fld_t sess[$];

  // Runs a session of the fields in sess and compares against the reference model.
  task automatic run_session(input string name, input logic [9:0] base, input int max_gap);
    logic [9:0]  ea[$];
    logic [31:0] ew[$];
    int          a = int'(base) & 32'h3FC;
    bit          eerr = 1'b0;
    foreach (sess[i]) begin
      if ($countones(sess[i].en) == 1) begin
        ea.push_back(10'(a)); ew.push_back(ref_encode(sess[i])); a = (a + 4) % 1024;
      end else begin
        eerr = 1'b1;
      end
    end
    clear_logs();
    do_start(base, 8'(sess.size()));
    foreach (sess[i]) begin
      int g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      if (g > 0) begin
        drop_valid();
        repeat (g - 1) @(negedge clk);
      end
      xfer(sess[i]);
    end
    drop_valid();
    wait_done(name);
    check({name, " writes"}, 32'(log_a.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < log_a.size(); i++) begin
      check($sformatf("%s addr[%0d]", name, i), 32'(log_a[i]), 32'(ea[i]));
      check($sformatf("%s word[%0d]", name, i), log_w[i], ew[i]);
    end
    check({name, " wr_count"}, 32'(bus.wr_count_o), 32'(ea.size()));
    check({name, " err"}, 32'(bus.err_o), 32'(eerr));
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{mk(TI,  7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5),       32'h00500093};
    tbl[1] = '{mk(TR,  7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0),       32'h002081B3};
    tbl[2] = '{mk(TS,  7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8),       32'h0020A423};
    tbl[3] = '{mk(TSB, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8),       32'h00208863};
    tbl[4] = '{mk(TU,  7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345),   32'h123452B7};
    tbl[5] = '{mk(TUJ, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h400),     32'h001000EF};

    bus.start_i = 1'b0; bus.base_addr_i = '0; bus.count_i = '0; bus.in_valid_i = 1'b0;
    drive(mk(6'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0));

    // Reset state
    #1;
    check("rst mem_we", 32'(bus.mem_we_o), 0);
    check("rst mem_addr", 32'(bus.mem_addr_o), 0);
    check("rst mem_wdata", bus.mem_wdata_o, 0);
    check("rst busy", 32'(bus.busy_o), 0);
    check("rst done", 32'(bus.done_o), 0);
    check("rst err", 32'(bus.err_o), 0);
    check("rst wr_count", 32'(bus.wr_count_o), 0);
    check("rst in_ready", 32'(bus.in_ready_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table vectors, back to back from base 0
    sess.delete();
    foreach (tbl[i]) sess.push_back(tbl[i].f);
    run_session("table", 10'h000, 0);
    for (int i = 0; i < 6 && i < log_w.size(); i++) begin
      check($sformatf("table const word[%0d]", i), log_w[i], tbl[i].word);
      check($sformatf("table const addr[%0d]", i), 32'(log_a[i]), 32'(4 * i));
    end
    check("table done after last write", 32'(done_cyc), 32'(last_we_cyc + 1));

    // Illegal type in the middle of a count-3 session
    sess.delete();
    sess.push_back(tbl[0].f);
    sess.push_back(mk(TR | TI, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0));
    sess.push_back(tbl[2].f);
    run_session("illegal", 10'h000, 0);
    if (log_w.size() == 2) begin
      check("illegal word0", log_w[0], tbl[0].word);
      check("illegal word1", log_w[1], tbl[2].word);
    end

    // Count zero; also shows err clears on an accepted start
    clear_logs();
    do_start(10'h040, 8'd0);
    check("cnt0 err cleared", 32'(bus.err_o), 0);
    repeat (4) @(negedge clk);
    #1;
    check("cnt0 writes", 32'(log_a.size()), 0);
    check("cnt0 busy cycles", 32'(busy_n), 1);
    check("cnt0 done cycle", 32'(done_cyc), 32'(st_cyc + 1));
    check("cnt0 wr_count", 32'(bus.wr_count_o), 0);

    // Wrap with gapped valid; ready must stay up while waiting
    clear_logs();
    do_start(10'h3FE, 8'd2);
    xfer(tbl[4].f);
    drop_valid();
    check("wrap ready gap0", 32'(bus.in_ready_o), 1);
    @(negedge clk);
    check("wrap ready gap1", 32'(bus.in_ready_o), 1);
    xfer(tbl[5].f);
    drop_valid();
    wait_done("wrap");
    check("wrap writes", 32'(log_a.size()), 2);
    if (log_a.size() == 2) begin
      check("wrap addr0", 32'(log_a[0]), 32'h3FC);
      check("wrap addr1", 32'(log_a[1]), 32'h000);
    end

    // start_i during LOAD is ignored
    clear_logs();
    do_start(10'h100, 8'd2);
    xfer(tbl[1].f);
    bus.start_i = 1'b1; bus.base_addr_i = 10'h200; bus.count_i = 8'd7;
    xfer(tbl[2].f);
    bus.start_i = 1'b0;
    drop_valid();
    wait_done("ignstart");
    repeat (3) @(negedge clk);
    check("ignstart writes", 32'(log_a.size()), 2);
    if (log_a.size() == 2) check("ignstart addr1", 32'(log_a[1]), 32'h104);
    check("ignstart idle", 32'(bus.busy_o), 0);

    // Reset after 2 of 5 transfers
    do_start(10'h000, 8'd5);
    xfer(tbl[0].f);
    xfer(tbl[1].f);
    #2 rst = 1'b1;
    #1;
    check("midrst mem_we", 32'(bus.mem_we_o), 0);
    check("midrst mem_addr", 32'(bus.mem_addr_o), 0);
    check("midrst mem_wdata", bus.mem_wdata_o, 0);
    check("midrst busy", 32'(bus.busy_o), 0);
    check("midrst wr_count", 32'(bus.wr_count_o), 0);
    check("midrst in_ready", 32'(bus.in_ready_o), 0);
    clear_logs();
    drive(tbl[2].f);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst no writes", 32'(log_a.size()), 0);
    check("midrst ready stays 0", 32'(bus.in_ready_o), 0);
    bus.in_valid_i = 1'b0;

    // Random sessions against the model
    for (int s = 0; s < 8; s++) begin
      logic [9:0] base = (s == 0) ? 10'h3F0 : 10'($urandom_range(1023, 0));
      int n = (s == 0) ? 8 : $urandom_range(8, 1);
      sess.delete();
      for (int i = 0; i < n; i++) begin
        logic [5:0] en;
        if ($urandom_range(7, 0) == 0) en = 6'($urandom_range(63, 0));
        else en = 6'(1 << $urandom_range(5, 0));
        sess.push_back(mk(en, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                          5'($urandom), 5'($urandom), $urandom));
      end
      run_session($sformatf("rand%0d", s), base, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
